cpu_sequencer: RTL

Multi-cycle control sequencer for the 18-bit-instruction, 16-bit-datapath CPU. It owns the program counter and instruction register, and fetches from a synchronous-read instruction memory. It steps each instruction through fetch / latch / execute, plus an extra write-back cycle for LOAD, and qualifies register, flag and data-memory writes. It evaluates JCOND branches against the ALU flags and sits between memory, the instruction decoder and the register file/ALU.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/branch_cond_eval.sv | 31 +++
 rtl/cpu_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and instruction-class decode for the
// multi-cycle CPU control path.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [3:0] RTYPE  = 4'b0000;
  localparam logic [3:0] MEM    = 4'b0100;
  localparam logic [3:0] LOAD_1 = 4'b0000;
  localparam logic [3:0] STOR_1 = 4'b0100;
  localparam logic [3:0] JCOND  = 4'b1100;
  localparam logic [3:0] CMP_1  = 4'b1011;
  localparam logic [3:0] CMPI   = 4'b1011;
  localparam logic [3:0] CMPUI  = 4'b1110;

  localparam logic [3:0] BEQ  = 4'b0000;
  localparam logic [3:0] BNEQ = 4'b0001;
  localparam logic [3:0] BGT  = 4'b0110;
  localparam logic [3:0] BLT  = 4'b0111;
  localparam logic [3:0] BLE  = 4'b1100;
  localparam logic [3:0] BGE  = 4'b1101;
  localparam logic [3:0] JUC  = 4'b1110;

  typedef struct packed {
    logic load;
    logic stor;
    logic jcond;
    logic cmp;
    logic li;
    logic alu;
  } iclass_t;

  // Anything that matches no class (format 01/10, unknown MEM sub-op) is a NOP.
  function automatic iclass_t decode_class(input logic [17:0] inst);
    iclass_t c;
    logic    fmt00;
    logic    is_mem;
    c      = '0;
    fmt00  = (inst[17:16] == 2'b00);
    is_mem = fmt00 && (inst[15:12] == MEM);
    c.load  = is_mem && (inst[7:4] == LOAD_1);
    c.stor  = is_mem && (inst[7:4] == STOR_1);
    c.jcond = is_mem && (inst[7:4] == JCOND);
    c.cmp   = fmt00 && (((inst[15:12] == RTYPE) && (inst[7:4] == CMP_1)) ||
                        (inst[15:12] == CMPI) || (inst[15:12] == CMPUI));
    c.li    = (inst[17:16] == 2'b11);
    c.alu   = fmt00 && !is_mem && !c.cmp;
    return c;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational JCOND condition evaluator: maps a 4-bit condition code and
// the Z/L/N flags to a taken/not-taken decision.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       l,
  input  logic       n,
  output logic       take
);

  // N is part of the flag bundle but no supported condition reads it.
  logic unused_n;
  assign unused_n = n;

  always_comb begin
    take = 1'b0;
    case (cond)
      JUC:     take = 1'b1;
      BEQ:     take = z;
      BNEQ:    take = !z;
      BGT:     take = !l && !z;
      BLT:     take = l;
      BGE:     take = !l;
      BLE:     take = l || z;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/latch/execute(/write-back) sequencer owning PC and IR.
// Optional retired-instruction counter enabled by CPU_SEQ_RETIRE_CNT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [17:0]     imem_rdata,
  input  logic [15:0]     reg_a_data,
  input  logic            flag_z,
  input  logic            flag_l,
  input  logic            flag_n,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic [17:0]     ir,
  output logic            reg_we,
  output logic            flags_we,
  output logic            dmem_we,
  output logic [31:0]     retired,
  output state_t          state_dbg
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  iclass_t         cls;
  logic            take;
  logic            last_cycle;

  assign cls       = decode_class(ir);
  assign imem_addr = pc;
  assign state_dbg = state;

  branch_cond_eval u_cond (
    .cond (ir[3:0]),
    .z    (flag_z),
    .l    (flag_l),
    .n    (flag_n),
    .take (take)
  );

  // Enables come only from state and ir, so they drop as soon as reset forces FETCH.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    reg_we     = 1'b0;
    flags_we   = 1'b0;
    dmem_we    = 1'b0;
    last_cycle = 1'b0;
    case (state)
      FETCH: if (run) state_nxt = LATCH;
      LATCH: state_nxt = EXEC;
      EXEC: begin
        reg_we     = cls.li || cls.alu;
        flags_we   = cls.cmp || cls.alu;
        dmem_we    = cls.stor;
        last_cycle = !cls.load;
        pc_nxt     = (cls.jcond && take) ? PC_W'(reg_a_data) : pc + PC_W'(1);
        state_nxt  = cls.load ? WB : FETCH;
      end
      WB: begin
        reg_we     = 1'b1;
        last_cycle = 1'b1;
        state_nxt  = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == LATCH) ir <= imem_rdata;
    end
  end

`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired_q <= '0;
    else if (last_cycle) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  logic unused_last_cycle;
  assign unused_last_cycle = last_cycle;
  assign retired = '0;
`endif

endmodule
